// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared constants and helpers for the text tile renderer
//
// Attribute byte layout: [7] blink, [6:4] background, [3:0] foreground.
// clog2 is a constant function usable in parameter and port width expressions.
package text_pkg;

    localparam int ATTR_FG    = 0;
    localparam int ATTR_BG    = 4;
    localparam int ATTR_BLINK = 7;

    // The cursor occupies the bottom CUR_ROWS glyph rows of its cell.
    localparam int CUR_ROWS = 2;

    localparam logic [3:0] BORDER_COLOR = 4'd0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/text_blink_timer.sv
// rtl/text_blink_timer.sv - frame-counting blink phase generator
//
// Ports:
//   i_clk    pixel clock
//   i_rst_n  asynchronous active-low reset
//   i_frame  one-cycle pulse per frame
//   o_phase  blink phase, toggles every BLINK_FRAMES frames
module text_blink_timer
    import text_pkg::*;
#(
    parameter int BLINK_FRAMES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_frame,
    output logic o_phase
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0] frame_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_cnt <= '0;
            o_phase   <= 1'b0;
        end else if (i_frame) begin
            if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                o_phase   <= ~o_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/text_tile_render.sv
// rtl/text_tile_render.sv - text-mode tile renderer, pixel coordinates to palette index
//
// Three-stage pipeline between the VGA timing generator and the palette stage.
// Ports:
//   i_clk, i_rst_n             pixel clock, asynchronous active-low reset
//   i_x, i_y, i_de, i_hs, i_vs raster position and timing from the timing generator
//   i_frame                    one-cycle pulse per frame (drives blink)
//   o_tram_addr, i_tram_data   text RAM: {attr, chr} returned one cycle after address
//   o_font_addr, i_font_row    font ROM: {chr, glyph row}, row returned one cycle later
//   i_cur_en, i_cur_col/row    cursor enable and cell position
//   o_color, o_de, o_hs, o_vs  palette index and timing, all delayed by 3 cycles
module text_tile_render
    import text_pkg::*;
#(
    parameter int FONT_W       = 8,
    parameter int FONT_H       = 8,
    parameter int SCALE_LOG2   = 0,
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int X_W          = 10,
    parameter int Y_W          = 10,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [X_W-1:0]                  i_x,
    input  logic [Y_W-1:0]                  i_y,
    input  logic                            i_de,
    input  logic                            i_hs,
    input  logic                            i_vs,
    input  logic                            i_frame,
    output logic [clog2(COLS*ROWS)-1:0]     o_tram_addr,
    input  logic [15:0]                     i_tram_data,
    output logic [8+clog2(FONT_H)-1:0]      o_font_addr,
    input  logic [FONT_W-1:0]               i_font_row,
    input  logic                            i_cur_en,
    input  logic [7:0]                      i_cur_col,
    input  logic [7:0]                      i_cur_row,
    output logic [3:0]                      o_color,
    output logic                            o_de,
    output logic                            o_hs,
    output logic                            o_vs
);

    localparam int FW_LOG2 = clog2(FONT_W);
    localparam int FH_LOG2 = clog2(FONT_H);
    localparam int TRAM_AW = clog2(COLS * ROWS);
    localparam int COL_W   = X_W - SCALE_LOG2 - FW_LOG2;
    localparam int ROW_W   = Y_W - SCALE_LOG2 - FH_LOG2;

    // Coordinate decode: dropping SCALE_LOG2 low bits replicates each glyph pixel.
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [FW_LOG2-1:0] xo;
    logic [FH_LOG2-1:0] yo;
    logic               in_area;
    logic               cur_pos;

    assign col = COL_W'(i_x >> (SCALE_LOG2 + FW_LOG2));
    assign xo  = FW_LOG2'(i_x >> SCALE_LOG2);
    assign row = ROW_W'(i_y >> (SCALE_LOG2 + FH_LOG2));
    assign yo  = FH_LOG2'(i_y >> SCALE_LOG2);

    assign in_area = (int'(col) < COLS) && (int'(row) < ROWS);

    // Cursor position is resolved here so cursor changes line up with the pixel
    // sampled in the same cycle; the blink phase gate is applied in S2.
    assign cur_pos = i_cur_en
                  && (int'(col) == int'(i_cur_col))
                  && (int'(row) == int'(i_cur_row))
                  && (int'(yo) >= FONT_H - CUR_ROWS);

    logic phase;

    text_blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_frame (i_frame),
        .o_phase (phase)
    );

    // S0: text RAM address and carried flags
    logic               s0_de, s0_hs, s0_vs, s0_in_area, s0_cur;
    logic [FW_LOG2-1:0] s0_xo;
    logic [FH_LOG2-1:0] s0_yo;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_tram_addr <= '0;
            s0_de       <= 1'b0;
            s0_hs       <= 1'b0;
            s0_vs       <= 1'b0;
            s0_in_area  <= 1'b0;
            s0_cur      <= 1'b0;
            s0_xo       <= '0;
            s0_yo       <= '0;
        end else begin
            // Out-of-area cells still produce an address; the colour is forced later.
            o_tram_addr <= TRAM_AW'(int'(row) * COLS + int'(col));
            s0_de       <= i_de;
            s0_hs       <= i_hs;
            s0_vs       <= i_vs;
            s0_in_area  <= in_area;
            s0_cur      <= cur_pos;
            s0_xo       <= xo;
            s0_yo       <= yo;
        end
    end

    // S1: capture attribute, issue font ROM address
    logic               s1_de, s1_hs, s1_vs, s1_in_area, s1_cur;
    logic [FW_LOG2-1:0] s1_xo;
    logic [7:0]         s1_attr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_font_addr <= '0;
            s1_attr     <= '0;
            s1_de       <= 1'b0;
            s1_hs       <= 1'b0;
            s1_vs       <= 1'b0;
            s1_in_area  <= 1'b0;
            s1_cur      <= 1'b0;
            s1_xo       <= '0;
        end else begin
            o_font_addr <= {i_tram_data[7:0], s0_yo};
            s1_attr     <= i_tram_data[15:8];
            s1_de       <= s0_de;
            s1_hs       <= s0_hs;
            s1_vs       <= s0_vs;
            s1_in_area  <= s0_in_area;
            s1_cur      <= s0_cur;
            s1_xo       <= s0_xo;
        end
    end

    // S2: pick the glyph bit (MSB is leftmost) and resolve the colour
    logic [FW_LOG2-1:0] pix_idx;
    logic               pix;
    logic               cur_hit;
    logic               on;
    logic [3:0]         color_next;

    assign pix_idx = FW_LOG2'(FONT_W - 1) - s1_xo;
    assign pix     = i_font_row[pix_idx];
    assign cur_hit = s1_cur && !phase;

    always_comb begin
        color_next = BORDER_COLOR;
        on         = pix ^ cur_hit;
        if (s1_attr[ATTR_BLINK] && phase) begin
            on = 1'b0;
        end
        if (s1_de && s1_in_area) begin
            color_next = on ? s1_attr[ATTR_FG +: 4] : {1'b0, s1_attr[ATTR_BG +: 3]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_color <= '0;
            o_de    <= 1'b0;
            o_hs    <= 1'b0;
            o_vs    <= 1'b0;
        end else begin
            o_color <= color_next;
            o_de    <= s1_de;
            o_hs    <= s1_hs;
            o_vs    <= s1_vs;
        end
    end

endmodule

// File: tb/tb_text_tile_render.sv
// tb/tb_text_tile_render.sv - scoreboard bench for text_tile_render
module tb_text_tile_render;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [9:0]  x, y;
    logic        de, de_s, hs, vs, frame, cur_en;
    logic [7:0]  cur_col, cur_row;

    logic [11:0] tram_addr, tram_addr_s;
    logic [15:0] tram_data, tram_data_s;
    logic [10:0] font_addr, font_addr_s;
    logic [7:0]  font_row, font_row_s;
    logic [3:0]  color, color_s;
    logic        de_o, hs_o, vs_o, de_o_s, hs_o_s, vs_o_s;

    logic [15:0] tram   [0:4095];
    logic [15:0] tram_s [0:4095];
    logic [7:0]  font   [0:2047];
    logic [7:0]  font_s [0:2047];

    assign tram_data   = tram[tram_addr];
    assign tram_data_s = tram_s[tram_addr_s];
    assign font_row    = font[font_addr];
    assign font_row_s  = font_s[font_addr_s];

    text_tile_render u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_x         (x),
        .i_y         (y),
        .i_de        (de),
        .i_hs        (hs),
        .i_vs        (vs),
        .i_frame     (frame),
        .o_tram_addr (tram_addr),
        .i_tram_data (tram_data),
        .o_font_addr (font_addr),
        .i_font_row  (font_row),
        .i_cur_en    (cur_en),
        .i_cur_col   (cur_col),
        .i_cur_row   (cur_row),
        .o_color     (color),
        .o_de        (de_o),
        .o_hs        (hs_o),
        .o_vs        (vs_o)
    );

    text_tile_render #(.SCALE_LOG2(1)) u_dut_s (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_x         (x),
        .i_y         (y),
        .i_de        (de_s),
        .i_hs        (hs),
        .i_vs        (vs),
        .i_frame     (frame),
        .o_tram_addr (tram_addr_s),
        .i_tram_data (tram_data_s),
        .o_font_addr (font_addr_s),
        .i_font_row  (font_row_s),
        .i_cur_en    (cur_en),
        .i_cur_col   (cur_col),
        .i_cur_row   (cur_row),
        .o_color     (color_s),
        .o_de        (de_o_s),
        .o_hs        (hs_o_s),
        .o_vs        (vs_o_s)
    );

    typedef struct packed {
        logic [3:0] color;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_s_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic pix(input int px, input int py, input logic [3:0] c);
        exp_t e;
        x = 10'(px); y = 10'(py); de = 1'b1; de_s = 1'b0;
        hs = px[0]; vs = py[1];
        e.color = c; e.hs = hs; e.vs = vs;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic pix_s(input int px, input int py, input logic [3:0] c);
        exp_t e;
        x = 10'(px); y = 10'(py); de = 1'b0; de_s = 1'b1;
        hs = px[0]; vs = py[1];
        e.color = c; e.hs = hs; e.vs = vs;
        exp_s_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        de = 1'b0; de_s = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame = 1'b1; @(posedge clk); #1;
            frame = 1'b0; @(posedge clk); #1;
        end
    endtask

    // Monitor: every presented pixel pops one expected entry
    always @(negedge clk) begin
        exp_t e;
        if (de_o === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL main_unexpected: colour %0d with no expected pixel", color);
            end else begin
                e = exp_q.pop_front();
                if ({color, hs_o, vs_o} !== {e.color, e.hs, e.vs}) begin
                    n_fail++;
                    $display("FAIL main_pixel: got colour %0d hs %0b vs %0b expected colour %0d hs %0b vs %0b",
                             color, hs_o, vs_o, e.color, e.hs, e.vs);
                end
            end
        end
        if (de_o_s === 1'b1) begin
            n_tests++;
            if (exp_s_q.size() == 0) begin
                n_fail++;
                $display("FAIL scale_unexpected: colour %0d with no expected pixel", color_s);
            end else begin
                e = exp_s_q.pop_front();
                if ({color_s, hs_o_s, vs_o_s} !== {e.color, e.hs, e.vs}) begin
                    n_fail++;
                    $display("FAIL scale_pixel: got colour %0d hs %0b vs %0b expected colour %0d hs %0b vs %0b",
                             color_s, hs_o_s, vs_o_s, e.color, e.hs, e.vs);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; x = '0; y = '0; de = 1'b0; de_s = 1'b0; hs = 1'b0; vs = 1'b0;
        frame = 1'b0; cur_en = 1'b0; cur_col = 8'd2; cur_row = 8'd0;
        for (int i = 0; i < 4096; i++) begin
            tram[i] = '0; tram_s[i] = '0;
        end
        for (int i = 0; i < 2048; i++) begin
            font[i] = '0; font_s[i] = '0;
        end
        tram[0]    = {8'h0F, 8'h41};  font[16'h41*8] = 8'b1000_0000;
        tram[81]   = {8'h1A, 8'h02};  font[2*8]      = 8'hFF;
        tram[80]   = {8'h0F, 8'h01};  font[1*8]      = 8'hFF;
        tram[2400] = {8'h0F, 8'h01};
        tram[2]    = {8'h1E, 8'h04};
        font[4*8+5] = 8'hF0; font[4*8+6] = 8'hF0; font[4*8+7] = 8'h0F;
        tram[3]    = {8'h8F, 8'h03};  font[3*8]      = 8'b1000_0000;
        tram_s[0]  = {8'h5C, 8'h07};
        font_s[7*8] = 8'b0100_0000;   font_s[7*8+1]  = 8'b1000_0000;

        repeat (3) @(posedge clk);
        #1;
        check("reset_color", color, 0);
        check("reset_de", de_o, 0);
        check("reset_hs", hs_o, 0);
        check("reset_vs", vs_o, 0);
        check("reset_tram_addr", tram_addr, 0);
        check("reset_font_addr", font_addr, 0);
        rst_n = 1'b1;

        // Basic fetch, addressing and border
        pix(0, 0, 4'd15);    check("tram_addr_0", tram_addr, 0);
        pix(1, 0, 4'd0);     check("font_addr_41", font_addr, 11'h208);
        pix(8, 8, 4'd10);    check("tram_addr_81", tram_addr, 81);
        pix(9, 8, 4'd10);    check("font_addr_02", font_addr, 11'h010);
        pix(640, 0, 4'd0);   check("tram_addr_80", tram_addr, 80);
        pix(0, 240, 4'd0);
        idle(5);

        // Reset mid-line flushes the pipeline
        pix(0, 0, 4'd15);
        pix(8, 8, 4'd10);
        pix(9, 8, 4'd10);
        check("pre_reset_de", de_o, 1);
        rst_n = 1'b0; x = 10'd16; y = 10'd8; de = 1'b1;
        #1;
        check("rst_color", color, 0);
        check("rst_de", de_o, 0);
        check("rst_tram_addr", tram_addr, 0);
        check("rst_font_addr", font_addr, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        pix(0, 0, 4'd15);  @(negedge clk); check("post_rst_c1_de", de_o, 0);
        pix(1, 0, 4'd0);   @(negedge clk); check("post_rst_c2_de", de_o, 0);
        pix(8, 8, 4'd10);  @(negedge clk); check("post_rst_c3_de", de_o, 1);
        idle(5);

        // Cursor at col 2 row 0, phase 0
        cur_en = 1'b1;
        pix(16, 5, 4'd14);
        pix(16, 6, 4'd1);
        pix(16, 7, 4'd14);
        pix(20, 7, 4'd1);
        cur_en = 1'b0;
        pix(16, 7, 4'd1);
        idle(5);

        // Blink: phase flips on the 16th frame pulse
        pix(24, 0, 4'd15);
        pix(0, 0, 4'd15);
        idle(4);
        frames(15);
        pix(24, 0, 4'd15);
        idle(4);
        frames(1);
        pix(24, 0, 4'd0);
        pix(0, 0, 4'd15);
        cur_en = 1'b1;
        pix(16, 7, 4'd1);
        pix(16, 6, 4'd14);
        cur_en = 1'b0;
        idle(4);
        frames(16);
        pix(24, 0, 4'd15);
        idle(5);

        // 2x scaling
        pix_s(0, 0, 4'd5);  pix_s(1, 0, 4'd5);  pix_s(2, 0, 4'd12); pix_s(3, 0, 4'd12);
        pix_s(0, 2, 4'd12); pix_s(1, 2, 4'd12); pix_s(2, 2, 4'd5);  pix_s(3, 2, 4'd5);
        idle(6);

        check("main_queue_drained", exp_q.size(), 0);
        check("scale_queue_drained", exp_s_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
